// File: rtl/mem_writer_if.sv
// mem_writer_if: load/readback bundle for mem_writer.
// master = source/consumer side, slave = mem_writer.
interface mem_writer_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = $clog2(DEPTH)
);
  logic                 start;
  logic                 wr_valid;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_ready;
  logic                 done;
  logic [LOG_DEPTH:0]   count;
  logic [LOG_DEPTH-1:0] rd_address;
  logic [WIDTH-1:0]     rd_data;
  logic [WIDTH-1:0]     checksum;

  modport master (
    output start,
    output wr_valid,
    output wr_data,
    output rd_address,
    input  wr_ready,
    input  done,
    input  count,
    input  rd_data,
    input  checksum
  );

  modport slave (
    input  start,
    input  wr_valid,
    input  wr_data,
    input  rd_address,
    output wr_ready,
    output done,
    output count,
    output rd_data,
    output checksum
  );
endinterface

// File: rtl/mem_writer.sv
// mem_writer: streams words into a DEPTH x WIDTH array at 0,1,2...
// and serves a 1-cycle registered read port.
// Ports: i_clk, i_reset (sync, active-high), bus (mem_writer_if.slave):
//   start, wr_valid/wr_data/wr_ready, done, count, rd_address/rd_data,
//   checksum.
// Option: define MEM_WRITER_CHECKSUM_EN to build the running checksum;
//   otherwise checksum is tied to 0.
module mem_writer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = $clog2(DEPTH)
) (
  input logic         i_clk,
  input logic         i_reset,
  mem_writer_if.slave bus
);

  localparam logic [LOG_DEPTH-1:0] LAST =
    LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0] FULL_CNT =
    (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } state_t;

  state_t               r_state;
  logic                 r_done;
  logic [LOG_DEPTH:0]   r_count;
  logic [LOG_DEPTH-1:0] r_ptr;
  logic [WIDTH-1:0]     r_rd_data;
  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic w_ready;
  logic w_hs;

  // Ready never looks at wr_valid; start masks it so a
  // restarting pass cannot swallow a word.
  assign w_ready = (r_state == ST_LOAD) && !bus.start;
  assign w_hs    = bus.wr_valid && w_ready && !i_reset;

  assign bus.wr_ready = w_ready;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.rd_data  = r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_count <= '0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_ptr   <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.start) begin
            r_count <= '0;
            r_ptr   <= '0;
          end else if (w_hs) begin
            if (r_ptr == LAST) begin
              r_state <= ST_FULL;
              r_done  <= 1'b1;
              r_count <= FULL_CNT;
              r_ptr   <= '0;
            end else begin
              r_count <= r_count + 1'b1;
              r_ptr   <= r_ptr + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (bus.start) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b0;
            r_count <= '0;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_count <= '0;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Storage is never cleared; old contents survive reset
  // and restarts until overwritten.
  always_ff @(posedge i_clk) begin
    if (w_hs)
      r_mem[r_ptr] <= bus.wr_data;
  end

  // Same-address read and write: the read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_rd_data <= '0;
    else
      r_rd_data <= r_mem[bus.rd_address];
  end

`ifdef MEM_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  // Start clears in every state; no handshake in FULL holds it.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.start)
      r_checksum <= '0;
    else if (w_hs)
      r_checksum <= r_checksum + bus.wr_data;
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// tb_mem_writer: directed test of mem_writer.
// Load, backpressure, restart, collision and reset cases.
module tb_mem_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_writer_if #(.WIDTH(8), .DEPTH(16)) bus ();

  mem_writer #(.WIDTH(8), .DEPTH(16)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ck(input logic [7:0] v);
`ifdef MEM_WRITER_CHECKSUM_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
  endtask

  task automatic pulse_start();
    bus.wr_valid = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic readback(input string tag,
                          input int n,
                          input logic [7:0] base);
    bus.wr_valid = 1'b0;
    for (int a = 0; a < n; a++) begin
      bus.rd_address = 4'(a);
      tick();
      chk(tag, bus.rd_data, 32'(base + 8'(a)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_rs [6];

    bus.start      = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.rd_address = 4'd0;

    // reset, then idle with data offered
    tick();
    tick();
    chk("rst_rd", bus.rd_data, 0);
    chk("rst_cnt", bus.count, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ck", bus.checksum, 0);
    reset        = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hAA;
    tick();
    tick();
    chk("idle_rdy", bus.wr_ready, 0);
    chk("idle_cnt", bus.count, 0);
    chk("idle_done", bus.done, 0);

    // full load 00..0F
    bus.wr_valid = 1'b0;
    bus.start    = 1'b1;
    #1;
    chk("start_rdy", bus.wr_ready, 0);
    tick();
    bus.start = 1'b0;
    #1;
    chk("load_rdy", bus.wr_ready, 1);
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("full_cnt", bus.count, 32'(i + 1));
      chk("full_done", bus.done, 32'(i == 15));
    end
    bus.wr_valid = 1'b0;
    chk("full_ck", bus.checksum, ck(8'h78));
    chk("full_rdy", bus.wr_ready, 0);
    readback("full_rd", 16, 8'h00);
    chk("full_hold", bus.done, 1);

    // backpressure: valid on even cycles only
    pulse_start();
    for (int k = 0; k < 31; k++) begin
      bus.wr_valid = (k % 2 == 0);
      bus.wr_data  = (k % 2 == 0) ? 8'(8'h20 + k / 2) : 8'hEE;
      tick();
      chk("bp_cnt", bus.count, 32'(k / 2 + 1));
      chk("bp_done", bus.done, 32'(k == 30));
    end
    bus.wr_valid = 1'b0;
    chk("bp_ck", bus.checksum, ck(8'h78));
    readback("bp_rd", 16, 8'h20);

    // restart after 5 words
    pulse_start();
    chk("rs_done", bus.done, 0);
    for (int i = 0; i < 5; i++)
      push(8'(8'h40 + i));
    chk("rs_cnt5", bus.count, 5);
    chk("rs_ck5", bus.checksum, ck(8'h4A));
    bus.wr_data = 8'h99;
    bus.start   = 1'b1;
    #1;
    chk("rs_rdy", bus.wr_ready, 0);
    tick();
    bus.start = 1'b0;
    chk("rs_cnt0", bus.count, 0);
    chk("rs_ck0", bus.checksum, 0);
    push(8'h77);
    bus.wr_valid = 1'b0;
    chk("rs_cnt1", bus.count, 1);
    chk("rs_ck1", bus.checksum, ck(8'h77));
    exp_rs = '{8'h77, 8'h41, 8'h42, 8'h43, 8'h44, 8'h25};
    for (int a = 0; a < 6; a++) begin
      bus.rd_address = 4'(a);
      tick();
      chk("rs_rd", bus.rd_data, 32'(exp_rs[a]));
    end

    // read/write collision at address 3
    pulse_start();
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    push(8'h11);
    pulse_start();
    push(8'hB0);
    push(8'hB1);
    push(8'hB2);
    bus.wr_data    = 8'h55;
    bus.rd_address = 4'd3;
    tick();
    chk("col_old", bus.rd_data, 8'h11);
    bus.wr_valid = 1'b0;
    tick();
    chk("col_new", bus.rd_data, 8'h55);

    // reset mid-load after 7 words
    pulse_start();
    for (int i = 0; i < 7; i++)
      push(8'(8'hC0 + i));
    bus.wr_valid   = 1'b0;
    bus.rd_address = 4'd2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_rd", bus.rd_data, 0);
    chk("mr_cnt", bus.count, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_ck", bus.checksum, 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h5A;
    #1;
    chk("mr_rdy", bus.wr_ready, 0);
    readback("mr_keep", 7, 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_writer.md
# mem_writer

Sequential memory loader and readback store: the write-side counterpart of the team's registered-output ROM. It accepts a stream of data words over a valid/ready handshake and writes them into an internal DEPTH×WIDTH array at auto-incrementing addresses starting from 0. It exposes a synchronous read port with the same one-cycle registered latency as the ROM. It sits between a data source (UART, test stimulus) and consumers that index the stored table.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of words (≥2)
- LOG_DEPTH, $clog2(DEPTH), address width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a new load pass at address 0
- wr_valid  input  1  source presents wr_data
- wr_data  input  WIDTH  word to store
- wr_ready  output  1  block accepts a word this cycle
- done  output  1  all DEPTH words of the current pass written
- count  output  LOG_DEPTH+1  words accepted in current pass
- rd_address  input  LOG_DEPTH  read index
- rd_data  output  WIDTH  registered read data
- checksum  output  WIDTH  running sum of accepted words (see Configuration)

## Operation
- States: IDLE, LOAD, FULL. Reset → IDLE.
- Reset values: state IDLE, done 0, count 0, internal write pointer 0, rd_data 0, checksum 0. Memory contents are not cleared by reset.
- wr_ready = (state == LOAD) && !start. It is combinational from state and start only, never from wr_valid.
- A handshake occurs when wr_valid && wr_ready at a rising edge. On a handshake:
  - mem[ptr] <= wr_data
  - ptr increments
  - count increments
  - checksum += wr_data (mod 2^WIDTH)
- IDLE: start → LOAD with ptr=0, count=0, checksum=0. Write data is ignored.
- LOAD: a handshake at ptr == DEPTH-1 → FULL, with done=1 and count=DEPTH. ptr then wraps to 0.
- LOAD + start: the pass restarts. ptr, count and checksum go to 0, and the state stays LOAD. wr_ready is low that cycle, so no word is lost silently.
- FULL: wr_ready=0 and done is held at 1. start → LOAD: done clears, ptr/count/checksum are zeroed, and the memory keeps its old contents until they are overwritten.
- Read port is independent of state: rd_data <= mem[rd_address] every clock, in all states.
- Read and write to the same address in the same cycle: read-before-write. rd_data returns the old contents, and the new value is visible on the next read.
- Reset mid-LOAD: returns to IDLE next edge. Words already written remain in memory.

## Timing
- Read latency: 1 cycle. rd_address sampled at edge N appears on rd_data after edge N.
- Write: a word accepted at edge N is readable with rd_address issued at edge N+1, appearing after edge N+1.
- start at edge N: wr_ready rises in cycle N+1 (combinationally low during the start cycle itself).
- Full-rate streaming: DEPTH consecutive handshakes complete a pass in DEPTH cycles. done is asserted the cycle after the final handshake.
- count, done and checksum are registered and update on the edge of the handshake.

## Configuration
- MEM_WRITER_CHECKSUM_EN defined:
  - checksum holds the mod-2^WIDTH sum of all words accepted in the current pass.
  - It is cleared by reset and by start, and held in FULL.
- MEM_WRITER_CHECKSUM_EN undefined:
  - The adder is not built. checksum is tied to 0. The port is still present.

## Test plan
- Reset then idle: with reset high 2 cycles, then wr_valid=1 wr_data=8'hAA with no start → wr_ready=0, count=0, done=0, rd_data=0 until a read of never-written memory.
- Full load: start, then stream 8'h00..8'h0F with wr_valid always high → done=1 after 16 handshakes, count=16, checksum=8'h78 (with macro). Reading addresses 0..15 returns 00..0F, each one cycle late.
- Backpressure from source: same pass with wr_valid toggling 1,0,1,0 → count increments only on valid cycles, data is stored in order, done after the 16th accepted word.
- Restart mid-pass: write 5 words, pulse start → wr_ready=0 that cycle, count=0, checksum=0. The next word lands at address 0 while addresses 1..4 keep their old values.
- Read/write collision: in LOAD at ptr=3 (mem[3]=8'h11), write 8'h55 while rd_address=3 → rd_data=8'h11. The next cycle's read of address 3 → 8'h55.
- Reset mid-LOAD after 7 words: state returns to IDLE, done=0, count=0. Reads of addresses 0..6 still return the written data.
